stub_bx_align: RTL and testbench

- Per-chamber BX alignment buffer that sits directly upstream of the primitive converter.
- Accepts CSC stubs from the MPC link unpacker. Each stub carries a 3-bit BX tag and may arrive a variable number of clocks after its BX.
- Holds each stub in a small ring buffer indexed by BX and presents all stubs of one BX, a fixed programmable delay later, on the converter's per-chamber stub bus (vpf, quality, wiregroup, hstrip, clctpat).
- Drops late and excess stubs and flags them.

---
 rtl/stub_pkg.sv | 23 ++
 rtl/stub_ring_entry.sv | 33 +++
 rtl/stub_bx_align.sv | 147 ++++++++++++++
 tb/tb_stub_bx_align.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stub_pkg.sv
// Shared stub record and widths for the BX alignment buffer and the primitive converter.
package stub_pkg;

  localparam int SEG_CH = 2;
  localparam int BW_WG  = 7;
  localparam int BW_HS  = 8;
  localparam int BXW    = 3;
  localparam int RING   = 1 << BXW;
  localparam int OCC_W  = $clog2(SEG_CH + 1);

  typedef struct packed {
    logic [3:0]       quality;
    logic [BW_WG-1:0] wg;
    logic [BW_HS-1:0] hs;
    logic [3:0]       clctpat;
  } stub_t;

  // Modular BX difference; the wrap falls out of the BXW-bit width.
  function automatic logic [BXW-1:0] bx_sub(input logic [BXW-1:0] a, input logic [BXW-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/stub_ring_entry.sv
// One BX slot of the alignment ring: up to SEG_CH stubs stored in arrival order.
module stub_ring_entry
  import stub_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    clr,
  input  stub_t                   push_stub,
  output stub_t [SEG_CH-1:0]      recs,
  output logic  [OCC_W-1:0]       occ,
  output logic                    full
);

  assign full = (occ == OCC_W'(SEG_CH));

  // clr wins over push; the top never issues both to the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      recs <= '0;
    end else if (clr) begin
      occ  <= '0;
      recs <= '0;
    end else if (push && !full) begin
      for (int k = 0; k < SEG_CH; k++) begin
        if (OCC_W'(k) == occ) recs[k] <= push_stub;
      end
      occ <= occ + OCC_W'(1);
    end
  end

endmodule

// File: rtl/stub_bx_align.sv
// Per-chamber BX alignment buffer: stubs are held by BX tag and replayed d_eff BX later.
// Optional error counters are enabled with `define STUB_ALIGN_ERRCNT_EN.
module stub_bx_align
  import stub_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bc0,
  input  logic [BXW-1:0]            delay,
  input  logic                      in_vld,
  input  logic [BXW-1:0]            in_bx,
  input  logic [3:0]                in_quality,
  input  logic [BW_WG-1:0]          in_wg,
  input  logic [BW_HS-1:0]          in_hs,
  input  logic [3:0]                in_clctpat,
  output logic [SEG_CH-1:0]         vpf,
  output logic [4*SEG_CH-1:0]       quality,
  output logic [BW_WG*SEG_CH-1:0]   wiregroup,
  output logic [BW_HS*SEG_CH-1:0]   hstrip,
  output logic [4*SEG_CH-1:0]       clctpat,
  output logic                      late_err,
  output logic                      ovf_err
`ifdef STUB_ALIGN_ERRCNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [15:0]               late_cnt,
  output logic [15:0]               ovf_cnt
`endif
);

  // in_vld qualifies one stub for one cycle. There is no ready: the buffer
  // never back-pressures, it drops late or excess stubs and pulses an error.

  logic [BXW-1:0]       bx_cnt;
  logic [BXW-1:0]       d_eff;
  logic [BXW-1:0]       age;
  logic [BXW-1:0]       rd_idx;
  logic                 is_late;
  logic                 slot_full;
  logic                 is_ovf;
  logic                 do_push;
  stub_t                in_stub;

  stub_t [SEG_CH-1:0]   ent_recs [RING];
  logic  [OCC_W-1:0]    ent_occ  [RING];
  logic  [RING-1:0]     ent_full;
  logic  [RING-1:0]     push_vec;
  logic  [RING-1:0]     clr_vec;

  stub_t [SEG_CH-1:0]   rd_recs;
  logic  [OCC_W-1:0]    rd_occ;

  logic [SEG_CH-1:0]        nxt_vpf;
  logic [4*SEG_CH-1:0]      nxt_quality;
  logic [BW_WG*SEG_CH-1:0]  nxt_wg;
  logic [BW_HS*SEG_CH-1:0]  nxt_hs;
  logic [4*SEG_CH-1:0]      nxt_clctpat;

  assign in_stub   = {in_quality, in_wg, in_hs, in_clctpat};
  assign d_eff     = (delay == '0) ? BXW'(1) : delay;
  assign age       = bx_sub(bx_cnt, in_bx);
  assign rd_idx    = bx_sub(bx_cnt, d_eff);
  assign is_late   = in_vld && (age >= d_eff);
  assign slot_full = ent_full[in_bx];
  assign is_ovf    = in_vld && !is_late && slot_full;
  assign do_push   = in_vld && !is_late && !slot_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bx_cnt <= '0;
    else if (bc0) bx_cnt <= '0;
    else bx_cnt <= bx_cnt + BXW'(1);
  end

  // A stub with in_bx == rd_idx is always late, so push and clear never hit one slot.
  for (genvar i = 0; i < RING; i++) begin : g_ring
    assign push_vec[i] = do_push && (in_bx == BXW'(i));
    assign clr_vec[i]  = (rd_idx == BXW'(i));

    stub_ring_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[i]),
      .clr       (clr_vec[i]),
      .push_stub (in_stub),
      .recs      (ent_recs[i]),
      .occ       (ent_occ[i]),
      .full      (ent_full[i])
    );
  end

  assign rd_recs = ent_recs[rd_idx];
  assign rd_occ  = ent_occ[rd_idx];

  always_comb begin
    nxt_vpf     = '0;
    nxt_quality = '0;
    nxt_wg      = '0;
    nxt_hs      = '0;
    nxt_clctpat = '0;
    for (int k = 0; k < SEG_CH; k++) begin
      if (OCC_W'(k) < rd_occ) begin
        nxt_vpf[k]                  = 1'b1;
        nxt_quality[4*k +: 4]       = rd_recs[k].quality;
        nxt_wg[BW_WG*k +: BW_WG]    = rd_recs[k].wg;
        nxt_hs[BW_HS*k +: BW_HS]    = rd_recs[k].hs;
        nxt_clctpat[4*k +: 4]       = rd_recs[k].clctpat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpf       <= '0;
      quality   <= '0;
      wiregroup <= '0;
      hstrip    <= '0;
      clctpat   <= '0;
      late_err  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      vpf       <= nxt_vpf;
      quality   <= nxt_quality;
      wiregroup <= nxt_wg;
      hstrip    <= nxt_hs;
      clctpat   <= nxt_clctpat;
      late_err  <= is_late;
      ovf_err   <= is_ovf;
    end
  end

`ifdef STUB_ALIGN_ERRCNT_EN
  // Saturating pulse counters; a clear in the same cycle as a pulse wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (cnt_clr) begin
      late_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (late_err && (late_cnt != 16'hFFFF)) late_cnt <= late_cnt + 16'd1;
      if (ovf_err  && (ovf_cnt  != 16'hFFFF)) ovf_cnt  <= ovf_cnt  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stub_bx_align.sv
// Scoreboarded bench for stub_bx_align: directed cases plus randomized traffic against a BX-bucket model.
module tb_stub_bx_align;
  import stub_pkg::*;

  localparam int W = SEG_CH*(1 + 4 + BW_WG + BW_HS + 4) + 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     bc0 = 1'b0;
  logic [BXW-1:0]           delay = '0;
  logic                     in_vld = 1'b0;
  logic [BXW-1:0]           in_bx = '0;
  logic [3:0]               in_quality = '0;
  logic [BW_WG-1:0]         in_wg = '0;
  logic [BW_HS-1:0]         in_hs = '0;
  logic [3:0]               in_clctpat = '0;
  logic [SEG_CH-1:0]        vpf;
  logic [4*SEG_CH-1:0]      quality;
  logic [BW_WG*SEG_CH-1:0]  wiregroup;
  logic [BW_HS*SEG_CH-1:0]  hstrip;
  logic [4*SEG_CH-1:0]      clctpat;
  logic                     late_err;
  logic                     ovf_err;
`ifdef STUB_ALIGN_ERRCNT_EN
  logic                     cnt_clr = 1'b0;
  logic [15:0]              late_cnt;
  logic [15:0]              ovf_cnt;
`endif

  stub_bx_align dut (
    .clk        (clk),
    .rst        (rst),
    .bc0        (bc0),
    .delay      (delay),
    .in_vld     (in_vld),
    .in_bx      (in_bx),
    .in_quality (in_quality),
    .in_wg      (in_wg),
    .in_hs      (in_hs),
    .in_clctpat (in_clctpat),
    .vpf        (vpf),
    .quality    (quality),
    .wiregroup  (wiregroup),
    .hstrip     (hstrip),
    .clctpat    (clctpat),
    .late_err   (late_err),
    .ovf_err    (ovf_err)
`ifdef STUB_ALIGN_ERRCNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .late_cnt   (late_cnt),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // reference model: per-BX buckets of stubs in arrival order
  int    m_bx;
  int    m_cnt [RING];
  stub_t m_rec [RING][SEG_CH];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 0;
    for (int i = 0; i < RING; i++) begin
      m_cnt[i] = 0;
      for (int k = 0; k < SEG_CH; k++) m_rec[i][k] = '0;
    end
  endtask

  task automatic drive_and_model(input bit b0, input logic [BXW-1:0] dl, input bit v,
                                 input logic [BXW-1:0] bx, input stub_t s);
    int d, age, rd, b;
    bit late, ovf;
    logic [SEG_CH-1:0]        e_vpf;
    logic [4*SEG_CH-1:0]      e_q;
    logic [BW_WG*SEG_CH-1:0]  e_wg;
    logic [BW_HS*SEG_CH-1:0]  e_hs;
    logic [4*SEG_CH-1:0]      e_cp;
    bc0 = b0; delay = dl; in_vld = v; in_bx = bx;
    in_quality = s.quality; in_wg = s.wg; in_hs = s.hs; in_clctpat = s.clctpat;
    d   = (dl == 0) ? 1 : int'(dl);
    b   = int'(bx);
    age = (m_bx - b + RING) % RING;
    rd  = (m_bx - d + RING) % RING;
    e_vpf = '0; e_q = '0; e_wg = '0; e_hs = '0; e_cp = '0;
    for (int k = 0; k < m_cnt[rd]; k++) begin
      e_vpf[k]              = 1'b1;
      e_q[4*k +: 4]         = m_rec[rd][k].quality;
      e_wg[BW_WG*k +: BW_WG] = m_rec[rd][k].wg;
      e_hs[BW_HS*k +: BW_HS] = m_rec[rd][k].hs;
      e_cp[4*k +: 4]        = m_rec[rd][k].clctpat;
    end
    m_cnt[rd] = 0;
    late = v && (age >= d);
    ovf  = 1'b0;
    if (v && !late) begin
      if (m_cnt[b] == SEG_CH) ovf = 1'b1;
      else begin
        m_rec[b][m_cnt[b]] = s;
        m_cnt[b]++;
      end
    end
    exp_q.push_back({e_vpf, e_q, e_wg, e_hs, e_cp, late, ovf});
    m_bx = b0 ? 0 : (m_bx + 1) % RING;
  endtask

  task automatic step(input bit b0, input logic [BXW-1:0] dl, input bit v,
                      input logic [BXW-1:0] bx, input stub_t s);
    @(negedge clk);
    drive_and_model(b0, dl, v, bx, s);
  endtask

  // after this, the next step() sees bx_cnt == t before its edge
  task automatic sync_to(input int t, input logic [BXW-1:0] dl);
    step(1'b1, dl, 1'b0, '0, '0);
    repeat (t) step(1'b0, dl, 1'b0, '0, '0);
  endtask

  function automatic stub_t mk(input logic [3:0] q, input logic [BW_WG-1:0] wg,
                               input logic [BW_HS-1:0] hs, input logic [3:0] cp);
    stub_t s;
    s.quality = q; s.wg = wg; s.hs = hs; s.clctpat = cp;
    return s;
  endfunction

  // monitor: one expected word per post-reset edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_underflow: got output with no expectation at %0t", $time);
      end else begin
        chk("cycle", {vpf, quality, wiregroup, hstrip, clctpat, late_err, ovf_err}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [BXW-1:0] dl;
    stub_t s;
    model_reset();
    #12;
    chk("reset_outputs", W'({vpf, quality, wiregroup, hstrip, clctpat, late_err, ovf_err}), '0);
`ifdef STUB_ALIGN_ERRCNT_EN
    chk("reset_counters", W'({late_cnt, ovf_cnt}), '0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive_and_model(1'b0, 3'd3, 1'b0, '0, '0);

    // basic alignment: delay 3, stub tagged 2 at bx_cnt 2, emitted after edge at bx_cnt 5
    sync_to(2, 3'd3);
    step(1'b0, 3'd3, 1'b1, 3'd2, mk(4'h9, 7'h12, 8'h55, 4'h3));
    step(1'b0, 3'd3, 1'b0, '0, '0);
    step(1'b0, 3'd3, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("basic_before", W'(vpf), W'(2'b00));
    step(1'b0, 3'd3, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("basic_vpf", W'(vpf), W'(2'b01));
    chk("basic_hs", W'(hstrip[7:0]), W'(8'h55));
    chk("basic_wg", W'(wiregroup[6:0]), W'(7'h12));
    step(1'b0, 3'd3, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("basic_after", W'(vpf), W'(2'b00));

    // two stubs in one BX, emitted together in arrival order
    sync_to(1, 3'd4);
    step(1'b0, 3'd4, 1'b1, 3'd1, mk(4'h1, 7'h01, 8'h10, 4'h1));
    step(1'b0, 3'd4, 1'b1, 3'd1, mk(4'h2, 7'h02, 8'h20, 4'h2));
    repeat (3) step(1'b0, 3'd4, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("pair_vpf", W'(vpf), W'(2'b11));
    chk("pair_hs", W'(hstrip), W'(16'h2010));
    repeat (8) step(1'b0, 3'd4, 1'b0, '0, '0);

    // overflow: third stub into BX 6 is dropped
    sync_to(6, 3'd4);
    step(1'b0, 3'd4, 1'b1, 3'd6, mk(4'hA, 7'h0A, 8'hA1, 4'hA));
    step(1'b0, 3'd4, 1'b1, 3'd6, mk(4'hB, 7'h0B, 8'hB2, 4'hB));
    step(1'b0, 3'd4, 1'b1, 3'd6, mk(4'hC, 7'h0C, 8'hC3, 4'hC));
    @(posedge clk); #2;
    chk("ovf_pulse", W'(ovf_err), W'(1'b1));
    repeat (8) step(1'b0, 3'd4, 1'b0, '0, '0);

    // late stub (age 2 at delay 2), then an in-time one that wraps to bx_cnt 0
    sync_to(7, 3'd2);
    step(1'b0, 3'd2, 1'b1, 3'd5, mk(4'h5, 7'h05, 8'h5A, 4'h5));
    @(posedge clk); #2;
    chk("late_pulse", W'(late_err), W'(1'b1));
    repeat (8) step(1'b0, 3'd2, 1'b0, '0, '0);
    sync_to(7, 3'd2);
    step(1'b0, 3'd2, 1'b1, 3'd6, mk(4'h6, 7'h06, 8'h6B, 4'h6));
    step(1'b0, 3'd2, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("wrap_vpf", W'(vpf), W'(2'b01));
    repeat (8) step(1'b0, 3'd2, 1'b0, '0, '0);

    // delay 0 behaves as delay 1
    sync_to(3, 3'd0);
    step(1'b0, 3'd0, 1'b1, 3'd3, mk(4'h7, 7'h33, 8'h77, 4'h7));
    step(1'b0, 3'd0, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("delay0_vpf", W'(vpf), W'(2'b01));
    chk("delay0_hs", W'(hstrip[7:0]), W'(8'h77));
    repeat (8) step(1'b0, 3'd0, 1'b0, '0, '0);

    // async reset between edges while entries are loaded
    sync_to(0, 3'd3);
    for (int i = 0; i < 4; i++)
      step(1'b0, 3'd3, 1'b1, 3'(i), mk(4'(i + 1), 7'(i + 8'h40), 8'(i + 8'hE0), 4'(i + 1)));
    @(posedge clk); #2;
    chk("prerst_vpf", W'(vpf), W'(2'b01));
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    chk("async_rst_outputs", W'({vpf, quality, wiregroup, hstrip, clctpat, late_err, ovf_err}), '0);
`ifdef STUB_ALIGN_ERRCNT_EN
    chk("async_rst_counters", W'({late_cnt, ovf_cnt}), '0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_and_model(1'b0, 3'd3, 1'b0, '0, '0);
    repeat (12) step(1'b0, 3'd3, 1'b0, '0, '0);

    // randomized traffic; delay changes only on a bc0 step
    for (int blk = 0; blk < 8; blk++) begin
      dl = 3'($urandom_range(0, 7));
      step(1'b1, dl, 1'b0, '0, '0);
      for (int n = 0; n < 60; n++) begin
        s = mk(4'($urandom), 7'($urandom), 8'($urandom), 4'($urandom));
        step(($urandom_range(0, 49) == 0), dl, ($urandom_range(0, 9) < 6),
             3'((m_bx - $urandom_range(0, 7) + RING) % RING), s);
      end
    end

    repeat (10) step(1'b0, 3'd1, 1'b0, '0, '0);
    @(posedge clk); #2;
    chk("queue_drained", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
